seq_div: RTL and testbench

- Sequential restoring divider; the inverse of the team's shift-add sequential multiplier.
- Loads an unsigned dividend and divisor on ld, then produces one quotient bit per clock.
- Presents quotient and remainder registers plus a done flag.
- Sits beside the multiplier in the lecture arithmetic set and shares its ld/a/b loading convention.

---
 rtl/arith_pkg.sv | 12 +
 rtl/div_step.sv | 34 +++
 rtl/seq_div.sv | 126 ++++++++++++
 tb/tb_seq_div.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the sequential arithmetic blocks (divider, multiplier).
package arith_pkg;

  localparam int ARITH_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift {rr,rq} left, trial-subtract rb.
module div_step
  import arith_pkg::*;
#(
  parameter int N = ARITH_W
) (
  input  logic [N:0]   rr_i,
  input  logic [N-1:0] rq_i,
  input  logic [N-1:0] rb_i,
  output logic [N:0]   rr_o,
  output logic [N-1:0] rq_o
);

  logic [N:0] sh_rr;
  logic [N:0] trial;
  logic       unused_rr_msb;

  // The stored partial remainder is always below the divisor, so its MSB is 0.
  assign unused_rr_msb = rr_i[N];

  assign sh_rr = {rr_i[N-1:0], rq_i[N-1]};
  assign trial = sh_rr - {1'b0, rb_i};

  always_comb begin
    if (!trial[N]) begin
      rr_o = trial;
      rq_o = {rq_i[N-2:0], 1'b1};
    end else begin
      rr_o = sh_rr;
      rq_o = {rq_i[N-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_div.sv
// Sequential restoring divider, one quotient bit per clock.
// Optional macro DIV_DBZ_EN: divide-by-zero short-cut with dbz flag.
module seq_div
  import arith_pkg::*;
#(
  parameter int N = ARITH_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] q,
  output logic [N-1:0] r,
  output logic         busy,
  output logic         done,
  output logic         dbz
);

  localparam int CW = $clog2(N + 1);

  state_t         state_q, state_d;
  logic [N:0]     rr_q, rr_d, rr_step;
  logic [N-1:0]   rq_q, rq_d, rq_step;
  logic [N-1:0]   rb_q, rb_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   q_q, q_d, r_q, r_d;
  logic           busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

  div_step #(.N(N)) u_step (
    .rr_i (rr_q),
    .rq_i (rq_q),
    .rb_i (rb_q),
    .rr_o (rr_step),
    .rq_o (rq_step)
  );

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    rq_d    = rq_q;
    rb_d    = rb_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    busy_d  = busy_q;
    done_d  = done_q;
    dbz_d   = dbz_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (ld) begin
          rr_d   = '0;
          rq_d   = a;
          rb_d   = b;
          done_d = 1'b0;
          dbz_d  = 1'b0;
`ifdef DIV_DBZ_EN
          if (b == '0) begin
            state_d = ST_DONE;
            cnt_d   = '0;
            q_d     = '1;
            r_d     = a;
            done_d  = 1'b1;
            dbz_d   = 1'b1;
          end else begin
            state_d = ST_RUN;
            cnt_d   = CW'(N);
            busy_d  = 1'b1;
          end
`else
          state_d = ST_RUN;
          cnt_d   = CW'(N);
          busy_d  = 1'b1;
`endif
        end
      end
      ST_RUN: begin
        // ld is deliberately ignored here; the captured operands run to completion.
        rr_d  = rr_step;
        rq_d  = rq_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_DONE;
          q_d     = rq_step;
          r_d     = rr_step[N-1:0];
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      rq_q    <= '0;
      rb_q    <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      rq_q    <= rq_d;
      rb_q    <= rb_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign q    = q_q;
  assign r    = r_q;
  assign busy = busy_q;
  assign done = done_q;
  assign dbz  = dbz_q;

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: directed cases plus randomized loads vs. an arithmetic model.
module tb_seq_div;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ld  = 1'b0;
  logic [N-1:0] a   = '0;
  logic [N-1:0] b   = '0;
  logic [N-1:0] q, r;
  logic         busy, done, dbz;

  int n_cmp = 0;
  int n_bad = 0;

  seq_div #(.N(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .ld   (ld),
    .a    (a),
    .b    (b),
    .q    (q),
    .r    (r),
    .busy (busy),
    .done (done),
    .dbz  (dbz)
  );

  always #5 clk = ~clk;

  // Reference: results from plain / and %, timing from the cycle at which the load was taken.
  logic [N-1:0] m_q, m_r, p_q, p_r;
  logic         m_busy, m_done, m_dbz;
  int           cyc, fin_cyc;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q <= '0; m_r <= '0; p_q <= '0; p_r <= '0;
      m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0;
      cyc <= 0; fin_cyc <= 0;
    end else begin
      cyc <= cyc + 1;
      if (m_busy) begin
        if (cyc == fin_cyc) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_q    <= p_q;
          m_r    <= p_r;
        end
      end else if (ld) begin
        m_done <= 1'b0;
        m_dbz  <= 1'b0;
`ifdef DIV_DBZ_EN
        if (b == '0) begin
          m_done <= 1'b1;
          m_dbz  <= 1'b1;
          m_q    <= '1;
          m_r    <= a;
        end else
`endif
        begin
          m_busy  <= 1'b1;
          fin_cyc <= cyc + N;
          p_q     <= (b == '0) ? '1 : a / b;
          p_r     <= (b == '0) ? a  : a % b;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      n_cmp++;
      if ({q, r, busy, done, dbz} !== {m_q, m_r, m_busy, m_done, m_dbz}) begin
        n_bad++;
        $display("FAIL cycle_cmp t=%0t got q=%b r=%b busy=%b done=%b dbz=%b exp q=%b r=%b busy=%b done=%b dbz=%b",
                 $time, q, r, busy, done, dbz, m_q, m_r, m_busy, m_done, m_dbz);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end else begin
      $display("ok   %s = %0h", name, got);
    end
  endtask

  task automatic do_ld(input logic [N-1:0] da, input logic [N-1:0] db);
    @(negedge clk);
    ld = 1'b1; a = da; b = db;
    @(negedge clk);
    ld = 1'b0; a = N'($urandom); b = N'($urandom);
  endtask

  // Edges counted after the load edge until done is seen; busy counted on the same samples.
  task automatic wait_done(input string name, output int lat, output int bcnt);
    lat  = 0;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout got done=%b exp done=1 within 20 cycles", name, done);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got no finish exp finish before 100us");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bc;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'({q, r, busy, done, dbz}), 32'd0);
    #2 rst = 1'b0;

    // 13 / 11
    do_ld(4'b1101, 4'b1011);
    wait_done("t1", lat, bc);
    chk("t1_latency", 32'(lat), 32'd4);
    chk("t1_busy_cycles", 32'(bc), 32'd4);
    chk("t1_qr", 32'({q, r}), 32'h12);
    chk("t1_model_qr", 32'({m_q, m_r}), 32'h12);

    // 9 / 6, then hold 100 ns with ld low
    do_ld(4'b1001, 4'b0110);
    wait_done("t2", lat, bc);
    chk("t2_qr", 32'({q, r}), 32'h13);
    repeat (10) @(negedge clk);
    chk("t2_hold", 32'({q, r, done}), 32'({4'd1, 4'd3, 1'b1}));

    // 15 / 1, then back-to-back 15 / 15 from DONE
    do_ld(4'b1111, 4'b0001);
    wait_done("t3a", lat, bc);
    chk("t3a_qr", 32'({q, r}), 32'hF0);
    ld = 1'b1; a = 4'b1111; b = 4'b1111;
    @(negedge clk);
    ld = 1'b0;
    chk("t3_b2b_start", 32'({busy, done}), 32'b10);
    wait_done("t3b", lat, bc);
    chk("t3b_latency", 32'(lat), 32'd4);
    chk("t3b_qr", 32'({q, r}), 32'h10);

    // 13 / 3 with an ignored ld (7 / 2) during RUN
    do_ld(4'b1101, 4'b0011);
    @(negedge clk);
    ld = 1'b1; a = 4'b0111; b = 4'b0010;
    @(negedge clk);
    ld = 1'b0;
    wait_done("t4", lat, bc);
    chk("t4_qr", 32'({q, r}), 32'h41);

    // 5 / 0
    do_ld(4'b0101, 4'b0000);
    wait_done("t5", lat, bc);
    chk("t5_qr", 32'({q, r}), 32'hF5);
`ifdef DIV_DBZ_EN
    chk("t5_dbz", 32'(dbz), 32'd1);
    chk("t5_latency", 32'(lat), 32'd0);
`else
    chk("t5_dbz", 32'(dbz), 32'd0);
    chk("t5_latency", 32'(lat), 32'd4);
`endif
    do_ld(4'b1101, 4'b0011);
    chk("t5_dbz_clear", 32'({dbz, busy}), 32'b01);
    wait_done("t5b", lat, bc);
    chk("t5b_qr", 32'({q, r}), 32'h41);

    // asynchronous reset between edges during RUN
    do_ld(4'b1101, 4'b0011);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("t6_async_rst", 32'({q, r, busy, done, dbz}), 32'd0);
    chk("t6_model_rst", 32'({m_q, m_r, m_busy, m_done, m_dbz}), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    do_ld(4'b1101, 4'b0011);
    wait_done("t6", lat, bc);
    chk("t6_qr", 32'({q, r}), 32'h41);

    // randomized loads, including mid-run ld and zero divisors
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      ld = ($urandom_range(0, 3) == 0);
      a  = N'($urandom);
      b  = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
    end
    @(negedge clk);
    ld = 1'b0;
    repeat (8) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
